// File: rtl/fc_pkg.sv
// fc_pkg: shared widths, int8 limits and the saturating narrow for the FC requant/pack block.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
package fc_pkg;

    localparam int FC_IN_W       = 21;                       // signed neuron sum
    localparam int FC_MULT_W     = 16;                       // unsigned requant multiplier
    localparam int FC_SHIFT_W    = 5;                        // right-shift amount 0..31
    localparam int FC_OUT_W      = 8;                        // int8 result
    localparam int FC_PACK_N     = 8;                        // lanes per output word
    localparam int FC_FIFO_DEPTH = 4;                        // output word FIFO depth
    localparam int FC_CNT_W      = 4;                        // lane count field, holds 0..8
    localparam int FC_PROD_W     = FC_IN_W + FC_MULT_W + 1;  // exact signed product, 38 bits
    localparam int FC_ACC_W      = FC_PROD_W + 2;            // room for rounding add and zero-point add

    localparam int INT8_MIN = -128;
    localparam int INT8_MAX = 127;

    // Clamp a wide signed value into the int8 range.
    function automatic logic signed [FC_OUT_W-1:0] sat_int8(input logic signed [FC_ACC_W-1:0] x);
        logic signed [FC_ACC_W-1:0] hi;
        logic signed [FC_ACC_W-1:0] lo;
        hi = FC_ACC_W'(INT8_MAX);
        lo = FC_ACC_W'(INT8_MIN);
        if (x > hi) begin
            return FC_OUT_W'(hi);
        end else if (x < lo) begin
            return FC_OUT_W'(lo);
        end else begin
            return FC_OUT_W'(x);
        end
    endfunction

endpackage

// File: rtl/fc_requant_pack_if.sv
// fc_requant_pack_if: element input stream plus packed-word output stream of the requant/pack block.
// Latency: n/a (wires only).
// Backpressure: input side has none (in_valid strobe); output side is valid/ready.
//   in_valid/in_data : one-cycle element strobe and signed sum
//   flush            : strobe, emit the partially filled word
//   out_valid/out_ready/out_data/out_cnt : FIFO head word and its number of valid lanes
//   master = upstream producer and writeback consumer, slave = fc_requant_pack
interface fc_requant_pack_if;
    import fc_pkg::*;

    logic                                in_valid;
    logic signed [FC_IN_W-1:0]           in_data;
    logic                                flush;
    logic                                out_valid;
    logic                                out_ready;
    logic [FC_PACK_N*FC_OUT_W-1:0]       out_data;
    logic [FC_CNT_W-1:0]                 out_cnt;

    modport master (
        output in_valid, in_data, flush, out_ready,
        input  out_valid, out_data, out_cnt
    );

    modport slave (
        input  in_valid, in_data, flush, out_ready,
        output out_valid, out_data, out_cnt
    );
endinterface

// File: rtl/fc_out_fifo.sv
// fc_out_fifo: small synchronous word FIFO, registered storage, no fall-through.
// Latency: a write is visible at the head the cycle after it is accepted.
// Backpressure: a write while full is refused unless a read frees a slot that same cycle.
//   clk, rst (sync, active-high) ; wr_en/wr_dat/full ; rd_en/rd_dat/empty
//   rd_dat reads as zero while empty so the head bus is clean after reset.
module fc_out_fifo #(
    parameter int WIDTH = 68,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_dat,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_dat,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_wr;
    logic             do_rd;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr[AW-1:0]] <= wr_dat;
        end
    end

    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fc_requant_pack.sv
// fc_requant_pack: requantize 21-bit FC sums to int8 and pack 8 per 64-bit word into an output FIFO.
// Latency: in_valid at cycle t -> completed word on out_valid at t+3 when the FIFO is empty.
// Backpressure: none upstream; a word pushed into a full FIFO is dropped and overflow sticks high.
//   clk, rst (sync, active-high)
//   bus (slave)  : in_valid/in_data/flush in, out_valid/out_ready/out_data/out_cnt out
//   cfg_mult/cfg_shift/cfg_zp : quasi-static requant settings, change only while idle
//   overflow : sticky word-drop flag ; busy : anything held in pipeline, packer or FIFO
//   Build option FC_RELU_EN: clamp each result to at least cfg_zp (quantized ReLU).
module fc_requant_pack
    import fc_pkg::*;
#(
    parameter int IN_W       = FC_IN_W,
    parameter int MULT_W     = FC_MULT_W,
    parameter int SHIFT_W    = FC_SHIFT_W,
    parameter int OUT_W      = FC_OUT_W,
    parameter int PACK_N     = FC_PACK_N,
    parameter int FIFO_DEPTH = FC_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst,
    fc_requant_pack_if.slave          bus,
    input  logic [MULT_W-1:0]         cfg_mult,
    input  logic [SHIFT_W-1:0]        cfg_shift,
    input  logic signed [OUT_W-1:0]   cfg_zp,
    output logic                      overflow,
    output logic                      busy
);
    localparam int PROD_W = IN_W + MULT_W + 1;
    localparam int ACC_W  = PROD_W + 2;
    localparam int LCW    = $clog2(PACK_N);
    localparam int CNT_W  = FC_CNT_W;
    localparam int WORD_W = PACK_N * OUT_W;
    localparam int ENT_W  = CNT_W + WORD_W;

    // ---------------- S1: exact signed product ----------------
    logic                     s1_vld;
    logic signed [PROD_W-1:0] s1_prod;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld  <= 1'b0;
            s1_prod <= '0;
        end else begin
            s1_vld <= bus.in_valid;
            if (bus.in_valid) begin
                // Zero-extend the multiplier so the product stays a signed*signed multiply.
                s1_prod <= $signed(bus.in_data) * $signed({1'b0, cfg_mult});
            end
        end
    end

    // ---------------- S2: round-shift, zero-point, saturate ----------------
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] rnd;
    logic signed [ACC_W-1:0] sh;
    logic signed [ACC_W-1:0] zp_x;
    logic signed [ACC_W-1:0] v_wide;
    logic signed [OUT_W-1:0] v_sat;
    logic signed [OUT_W-1:0] v_out;
    logic [SHIFT_W-1:0]      shift_m1;

    always_comb begin
        prod_x   = {{(ACC_W-PROD_W){s1_prod[PROD_W-1]}}, s1_prod};
        shift_m1 = cfg_shift - SHIFT_W'(1);
        // Half-LSB bias before an arithmetic shift gives round-half-up toward +inf.
        rnd      = (cfg_shift == '0) ? '0 : (ACC_W'(1) <<< shift_m1);
        sh       = (prod_x + rnd) >>> cfg_shift;
        zp_x     = {{(ACC_W-OUT_W){cfg_zp[OUT_W-1]}}, cfg_zp};
        v_wide   = sh + zp_x;
        v_sat    = sat_int8(v_wide);
`ifdef FC_RELU_EN
        v_out    = (v_sat < cfg_zp) ? cfg_zp : v_sat;
`else
        v_out    = v_sat;
`endif
    end

    logic                    s2_vld;
    logic signed [OUT_W-1:0] s2_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_vld <= 1'b0;
            s2_val <= '0;
        end else begin
            s2_vld <= s1_vld;
            if (s1_vld) begin
                s2_val <= v_out;
            end
        end
    end

    // ---------------- S3: lane packer ----------------
    // Lanes above lane_cnt are always zero, so a partial word needs no extra masking.
    logic [PACK_N-1:0][OUT_W-1:0] lanes_q;
    logic [PACK_N-1:0][OUT_W-1:0] lanes_nxt;
    logic [LCW-1:0]               lane_cnt;
    logic [CNT_W-1:0]             cnt_nxt;
    logic                         push_vld;
    logic [ENT_W-1:0]             push_dat;

    always_comb begin
        lanes_nxt = lanes_q;
        cnt_nxt   = {1'b0, lane_cnt};
        if (s2_vld) begin
            lanes_nxt[lane_cnt] = s2_val;
            cnt_nxt             = {1'b0, lane_cnt} + CNT_W'(1);
        end
        // An arriving element is merged before the flush decision, so a flush that
        // completes the word yields exactly one full push.
        push_vld = (cnt_nxt == CNT_W'(PACK_N)) || (bus.flush && (cnt_nxt != '0));
        push_dat = {cnt_nxt, lanes_nxt};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lanes_q  <= '0;
            lane_cnt <= '0;
        end else if (push_vld) begin
            lanes_q  <= '0;
            lane_cnt <= '0;
        end else begin
            lanes_q  <= lanes_nxt;
            lane_cnt <= cnt_nxt[LCW-1:0];
        end
    end

    // ---------------- output FIFO ----------------
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic [ENT_W-1:0] head;

    assign pop = bus.out_valid && bus.out_ready;

    fc_out_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (push_vld),
        .wr_dat (push_dat),
        .full   (fifo_full),
        .rd_en  (pop),
        .rd_dat (head),
        .empty  (fifo_empty)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.out_cnt   = head[ENT_W-1:WORD_W];
    assign bus.out_data  = head[WORD_W-1:0];

    // A pop in the same cycle frees a slot, so only an unrelieved full FIFO drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push_vld && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    assign busy = s1_vld || s2_vld || (lane_cnt != '0) || !fifo_empty;

endmodule

// File: tb/tb_fc_requant_pack.sv
// tb_fc_requant_pack: directed vectors with hand-computed words for fc_requant_pack.
// Latency: checks the t+3 word latency and flush/overflow/reset behaviour.
// Backpressure: exercises out_ready=0 with FIFO overfill, then drains.
module tb_fc_requant_pack;
    import fc_pkg::*;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_mult;
    logic [4:0]  cfg_shift;
    logic signed [7:0] cfg_zp;
    logic        overflow;
    logic        busy;

    int checks = 0;
    int errors = 0;

    fc_requant_pack_if bus ();

    fc_requant_pack dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus.slave),
        .cfg_mult  (cfg_mult),
        .cfg_shift (cfg_shift),
        .cfg_zp    (cfg_zp),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic send(input logic signed [20:0] d);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    task automatic set_cfg(input logic [15:0] m, input logic [4:0] s, input logic signed [7:0] z);
        cfg_mult  = m;
        cfg_shift = s;
        cfg_zp    = z;
    endtask

    // Wait (bounded) for a head word, compare it, then pop it.
    task automatic expect_word(input string tag, input logic [63:0] d, input logic [3:0] c);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, 68'(bus.out_valid), 68'(1));
        chk({tag, "_dat"}, 68'(bus.out_data), 68'(d));
        chk({tag, "_cnt"}, 68'(bus.out_cnt), 68'(c));
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] relu_word;

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        set_cfg(16'd1, 5'd0, 8'sd0);
        repeat (3) tick();

        // Reset state
        chk("rst_vld",  68'(bus.out_valid), 68'(0));
        chk("rst_dat",  68'(bus.out_data),  68'(0));
        chk("rst_cnt",  68'(bus.out_cnt),   68'(0));
        chk("rst_ovf",  68'(overflow),      68'(0));
        chk("rst_busy", 68'(busy),          68'(0));
        rst = 1'b0;
        tick();

        // 1: identity requant, 8 back-to-back elements, word at t+3 of the last element
        for (int i = 1; i <= 8; i++) send(21'(i));
        tick();
        chk("t1_lat2", 68'(bus.out_valid), 68'(0));
        tick();
        chk("t1_lat3", 68'(bus.out_valid), 68'(1));
        expect_word("t1", 64'h0807060504030201, 4'd8);

        // 2: saturation both sides: 3000/16 -> 188 -> 127 ; -3000/16 -> -187 -> -128
        set_cfg(16'd3, 5'd4, 8'sd0);
        send(21'sd1000);
        send(-21'sd1000);
        repeat (3) tick();
        do_flush();
        expect_word("t2", 64'h0000_0000_0000_807F, 4'd2);

        // 3: rounding + negative zero-point: 5 -> 3-3=0 ; -4 -> -2-3=-5 (ReLU: -3)
        set_cfg(16'd1, 5'd1, -8'sd3);
        send(21'sd5);
        send(-21'sd4);
        repeat (3) tick();
        do_flush();
`ifdef FC_RELU_EN
        relu_word = 64'h0000_0000_0000_FD00;
`else
        relu_word = 64'h0000_0000_0000_FB00;
`endif
        expect_word("t3", relu_word, 4'd2);

        // 4: partial word by flush, then an empty flush emits nothing
        set_cfg(16'd1, 5'd0, 8'sd0);
        send(21'sd10);
        send(21'sd20);
        send(21'sd30);
        repeat (3) tick();
        do_flush();
        expect_word("t4", 64'h0000_0000_001E_140A, 4'd3);
        do_flush();
        repeat (3) tick();
        chk("t4_noword", 68'(bus.out_valid), 68'(0));
        chk("t4_idle",   68'(busy),          68'(0));

        // 4b: flush arriving with the 8th element gives exactly one full word
        for (int i = 1; i <= 8; i++) send(21'(i + 16));
        tick();
        do_flush();
        expect_word("t4b", 64'h1817161514131211, 4'd8);
        repeat (2) tick();
        chk("t4b_single", 68'(bus.out_valid), 68'(0));
        chk("t4b_idle",   68'(busy),          68'(0));

        // 5: 5 full words into a 4-deep FIFO with no consumer
        for (int i = 1; i <= 40; i++) send(21'(i));
        repeat (4) tick();
        chk("t5_ovf",  68'(overflow),      68'(1));
        chk("t5_vld",  68'(bus.out_valid), 68'(1));
        expect_word("t5_w0", 64'h0807060504030201, 4'd8);
        expect_word("t5_w1", 64'h100F0E0D0C0B0A09, 4'd8);
        expect_word("t5_w2", 64'h1817161514131211, 4'd8);
        expect_word("t5_w3", 64'h201F1E1D1C1B1A19, 4'd8);
        chk("t5_empty", 68'(bus.out_valid), 68'(0));
        chk("t5_idle",  68'(busy),          68'(0));

        // 6: reset with 5 lanes pending and 2 words queued
        for (int i = 1; i <= 21; i++) send(21'(i));
        repeat (3) tick();
        chk("t6_busy_pre", 68'(busy), 68'(1));
        rst = 1'b1;
        tick();
        chk("t6_vld",  68'(bus.out_valid), 68'(0));
        chk("t6_busy", 68'(busy),          68'(0));
        chk("t6_ovf",  68'(overflow),      68'(0));
        chk("t6_cnt",  68'(bus.out_cnt),   68'(0));
        rst = 1'b0;
        repeat (2) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
